// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: state encoding, opcode and command-field helpers shared by the ALU sequencer.
package alu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST   = 5'b00001,
    S_IDLE  = 5'b00010,
    S_FETCH = 5'b00100,
    S_LOAD  = 5'b01000,
    S_EXEC  = 5'b10000
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int nop_op(input int nops);
    return 1 << nops;
  endfunction

  // Command layout is {sel_a, sel_b, op_idx}, MSB to LSB.
  function automatic int ofs_op();
    return 0;
  endfunction

  function automatic int ofs_b(input int opselw);
    return opselw;
  endfunction

  function automatic int ofs_a(input int opselw, input int selw);
    return opselw + selw;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences datain/aluin/aluout register loads, operand selects and opcode for one
// latched command, with a multi-cycle op and a saturating count of feedback-parity-invalid results.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int SELW      = clog2(NSRC),
  parameter int NOPS      = 4,
  parameter int OPSELW    = clog2(NOPS),
  parameter int CMDW      = 2 * SELW + OPSELW,
  parameter int MC_OP     = 3,
  parameter int MC_CYCLES = 3,
  parameter int ERRW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [CMDW-1:0]   cmd_in,
  output logic              cmd_ready,
  input  logic              p_error,
  output logic              datain_reg_en,
  output logic              aluin_reg_en,
  output logic              aluout_reg_en,
  output logic [SELW-1:0]   in_select_a,
  output logic [SELW-1:0]   in_select_b,
  output logic [NOPS:0]     opcode,
  output logic              result_valid,
  output logic              nvalid_data,
  output logic [ERRW-1:0]   err_count
);

  localparam int CNTW = clog2(MC_CYCLES + 1);
  localparam int OA = ofs_a(OPSELW, SELW);
  localparam int OB = ofs_b(OPSELW);
  localparam int OO = ofs_op();
  localparam logic [NOPS:0] NOP = (NOPS + 1)'(nop_op(NOPS));

  state_e state_q, state_d;
  logic [CMDW-1:0] cmd_q, cmd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [ERRW-1:0] err_q;
  logic [SELW-1:0] sel_a, sel_b;
  logic [OPSELW-1:0] op;
  logic fb, op_ok;

  assign sel_a = cmd_q[OA +: SELW];
  assign sel_b = cmd_q[OB +: SELW];
  assign op = cmd_q[OO +: OPSELW];
  assign fb = (sel_a == SELW'(NSRC - 1)) || (sel_b == SELW'(NSRC - 1));
  // Indices past NOPS only exist when NOPS is not a power of two; they execute as NOP.
  assign op_ok = {1'b0, op} < (OPSELW + 1)'(NOPS);
  assign err_count = err_q;

  always_ff @(posedge clk) begin
    state_q <= rst ? S_RST : state_d;
    cmd_q <= rst ? '0 : cmd_d;
    cnt_q <= rst ? '0 : cnt_d;
    err_q <= rst ? '0 : (nvalid_data && !(&err_q)) ? err_q + 1'b1 : err_q;
  end

  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    cmd_ready = 1'b0;
    datain_reg_en = 1'b0;
    aluin_reg_en = 1'b0;
    aluout_reg_en = 1'b0;
    result_valid = 1'b0;
    nvalid_data = 1'b0;
    in_select_a = sel_a;
    in_select_b = sel_b;
    opcode = NOP;
    unique case (state_q)
      S_RST: begin
        in_select_a = '0;
        in_select_b = '0;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d = cmd_in;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        datain_reg_en = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        aluin_reg_en = 1'b1;
        cnt_d = (op == OPSELW'(MC_OP)) ? CNTW'(MC_CYCLES - 1) : '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        opcode = op_ok ? (NOPS + 1)'(1) << op : NOP;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          aluout_reg_en = 1'b1;
          result_valid = 1'b1;
          nvalid_data = p_error & fb;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a 2-bit error counter to reach saturation.
module tb_alu_seq_ctrl;
  logic clk = 0, rst = 1, cmd_valid = 0, p_error = 0;
  logic [5:0] cmd_in = '0;
  logic cmd_ready, datain_reg_en, aluin_reg_en, aluout_reg_en, result_valid, nvalid_data;
  logic [1:0] in_select_a, in_select_b, err_count;
  logic [4:0] opcode;
  int errors = 0, checks = 0, err_m = 0;
  typedef struct {logic [5:0] c; logic nv;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.ERRW(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_in(cmd_in), .cmd_ready(cmd_ready),
    .p_error(p_error), .datain_reg_en(datain_reg_en), .aluin_reg_en(aluin_reg_en),
    .aluout_reg_en(aluout_reg_en), .in_select_a(in_select_a), .in_select_b(in_select_b),
    .opcode(opcode), .result_valid(result_valid), .nvalid_data(nvalid_data), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] eo;
    if (result_valid) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        eo = 5'd1 << e.c[1:0];
        chk("res_opcode", opcode, eo);
        chk("res_sel_a", in_select_a, e.c[5:4]);
        chk("res_sel_b", in_select_b, e.c[3:2]);
        chk("res_nvalid", nvalid_data, e.nv);
      end
    end
  end

  task automatic run_cmd(input logic [5:0] c, input logic pe);
    int n, lat;
    logic nv;
    logic [4:0] eo;
    lat = (c[1:0] == 2'd3) ? 3 : 1;
    eo = 5'd1 << c[1:0];
    nv = pe & (c[5:4] == 2'd3 || c[3:2] == 2'd3);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", cmd_ready, 1);
    chk("idle_opcode", opcode, 5'b10000);
    cmd_valid = 1;
    cmd_in = c;
    p_error = pe;
    sb.push_back('{c, nv});
    @(negedge clk);
    cmd_valid = 0;
    cmd_in = 6'($urandom);
    chk("fetch_den", datain_reg_en, 1);
    chk("fetch_aen", aluin_reg_en, 0);
    chk("fetch_ready", cmd_ready, 0);
    @(negedge clk);
    cmd_in = 6'($urandom);
    chk("load_aen", aluin_reg_en, 1);
    chk("load_den", datain_reg_en, 0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      cmd_in = 6'($urandom);
      chk("exec_opcode", opcode, eo);
      chk("exec_sel", {in_select_a, in_select_b}, c[5:2]);
      chk("exec_oen", aluout_reg_en, i == lat - 1);
      chk("exec_rv", result_valid, i == lat - 1);
      chk("exec_ready", cmd_ready, 0);
    end
    @(negedge clk);
    if (nv && err_m < 3) err_m++;
    chk("err_count", err_count, err_m);
    chk("ready_again", cmd_ready, 1);
    p_error = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_opcode", opcode, 5'b10000);
    chk("rst_en", {datain_reg_en, aluin_reg_en, aluout_reg_en, result_valid}, 0);
    chk("rst_err", err_count, 0);
    @(negedge clk);
    chk("idle_ready0", cmd_ready, 1);
    chk("idle_opcode0", opcode, 5'b10000);
    run_cmd(6'b00_01_01, 0);
    run_cmd(6'b01_10_11, 0);
    run_cmd(6'b11_00_00, 1);
    run_cmd(6'b10_00_00, 1);
    run_cmd(6'b11_00_00, 0);
    // abort a multi-cycle op at t+4
    cmd_valid = 1;
    cmd_in = 6'b11_10_11;
    p_error = 1;
    @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    chk("abort_opcode", opcode, 5'b01000);
    @(negedge clk);
    chk("abort_rv4", result_valid, 0);
    rst = 1;
    @(negedge clk);
    chk("abort_rv5", result_valid, 0);
    chk("abort_oen", aluout_reg_en, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_opcode_nop", opcode, 5'b10000);
    chk("abort_sel", {in_select_a, in_select_b}, 0);
    chk("abort_err", err_count, 0);
    rst = 0;
    p_error = 0;
    err_m = 0;
    run_cmd(6'b11_00_00, 1);
    run_cmd(6'b00_11_10, 1);
    run_cmd(6'b11_11_11, 1);
    run_cmd(6'b11_00_01, 1);
    run_cmd(6'b11_01_10, 1);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Parametrised next-generation ALU datapath sequencer.
- Accepts operand-select/opcode commands over a valid/ready handshake and latches them.
- Drives the datain, aluin and aluout register enables, the operand muxes and a one-hot opcode with a NOP bit.
- Supports one multi-cycle operation and flags results computed from a faulty feedback path; keeps a saturating error count.
- Sits between the command source and the ALU datapath.

Parameters:
NSRC, 4, number of operand sources per mux; index NSRC-1 is the ALU feedback path.
SELW, 2, select width, clog2(NSRC).
NOPS, 4, number of ALU operations; opcode is NOPS+1 bits, bit NOPS = NOP.
OPSELW, 2, opcode-index field width, clog2(NOPS).
CMDW, 2*SELW+OPSELW (6), command width; fields {sel_a, sel_b, op_idx} MSB to LSB.
MC_OP, 3, op index that executes over multiple cycles.
MC_CYCLES, 3, EXEC length for MC_OP; must be >= 1.
ERRW, 8, error counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
cmd_valid  in  1  command present.
cmd_in  in  CMDW  command {sel_a, sel_b, op_idx}.
cmd_ready  out  1  sequencer can accept a command.
p_error  in  1  parity error on the feedback path.
datain_reg_en  out  1  input data register load.
aluin_reg_en  out  1  ALU operand register load.
aluout_reg_en  out  1  ALU result register load.
in_select_a  out  SELW  operand A mux select (latched).
in_select_b  out  SELW  operand B mux select (latched).
opcode  out  NOPS+1  one-hot op, or NOP = 1<<NOPS.
result_valid  out  1  one-cycle pulse when the result is loaded.
nvalid_data  out  1  result is invalid (feedback operand with parity error).
err_count  out  ERRW  saturating count of nvalid_data pulses.

Behaviour:
- States: RST, IDLE, FETCH, LOAD, EXEC. State register is synchronous; all outputs are decoded from the state plus the latched command.
- rst=1: next state RST. cmd_reg, exec counter and err_count clear to 0.
- RST outputs: all enables 0, cmd_ready 0, result_valid 0, nvalid_data 0, selects 0, opcode NOP. RST -> IDLE unconditionally.
- IDLE: cmd_ready=1, opcode NOP. cmd_valid&cmd_ready latches cmd_in into cmd_reg and moves to FETCH.
  - No handshake: stay in IDLE.
  - cmd_in is ignored outside the handshake cycle.
  - cmd_ready=0 in every state except IDLE.
- FETCH: datain_reg_en=1, then -> LOAD.
- LOAD: aluin_reg_en=1, then -> EXEC. Exec counter loads MC_CYCLES-1 if op_idx==MC_OP, else 0.
- EXEC: opcode = 1<<op_idx for every EXEC cycle.
  - Counter != 0: decrement, stay in EXEC, aluout_reg_en=0.
  - Counter == 0 (last cycle): aluout_reg_en=1, result_valid=1, nvalid_data = p_error & (sel_a==NSRC-1 | sel_b==NSRC-1), then -> IDLE.
- in_select_a/b come from cmd_reg in all states except RST, where they are 0.
- op_idx >= NOPS (only possible when NOPS is not a power of 2): treated as NOP for the whole EXEC; result_valid still pulses.
- Latency, handshake at cycle t: datain_reg_en at t+1, aluin_reg_en at t+2, result at t+3 (single-cycle op) or t+2+MC_CYCLES (MC_OP). cmd_ready reasserts on the cycle after the last EXEC cycle.
- err_count increments in the cycle nvalid_data=1 and saturates at all-ones (no wrap).
- Reset mid-operation: the operation is abandoned. No result_valid or aluout_reg_en; outputs take RST values on the next cycle.
- p_error is sampled only in the last EXEC cycle.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state encoding (one-hot, 5 bits);
  - the NOP opcode constant builder;
  - command field offset constants;
  - a clog2 function.
- No sub-module; the exec counter and err counter are inline.

Test Plan:
- Reset: hold rst 2 cycles, then release. All enables 0, opcode 5'b10000, cmd_ready 0 the first cycle, then 1.
- Single op: handshake cmd 6'b00_01_01 at t. datain_reg_en at t+1, aluin_reg_en at t+2. At t+3: opcode 5'b00010, aluout_reg_en=1, result_valid=1, selects a=0, b=1. cmd_ready=1 at t+4.
- Multi-cycle op: cmd 6'b01_10_11. opcode 5'b01000 at t+3..t+5. aluout_reg_en and result_valid only at t+5; cmd_ready at t+6.
- Feedback error:
  - cmd 6'b11_00_00 with p_error=1: nvalid_data=1 at t+3, err_count 0->1.
  - Same with sel_a=2'b10: nvalid_data=0.
- Saturation (ERRW=2): 5 consecutive feedback-error commands give err_count 1,2,3,3,3.
- Abort and stability:
  - rst at t+4 of an MC_OP: no result_valid; RST outputs at t+5.
  - Toggling cmd_in during FETCH..EXEC leaves the selects and opcode unchanged.
